// File: rtl/lamp_fpu_sqrt_round_pkg.sv
// Shared types and helpers for the sqrt result rounding/packing slice.
//  LAMP_FLOAT_DW   width of a packed LAMP float {s, e[7:0], frac[6:0]}
//  RES_FIFO_DW     width of one buffered result {flags[1:0], float[15:0]}
//  lampRndFlags_t  {overflow, inexact} status attached to every result
//  FUNC_rndNearestEven  round-to-nearest-even plus mantissa-carry normalisation
package lamp_fpu_sqrt_round_pkg;

   localparam int LAMP_FLOAT_DW   = 16;
   localparam int LAMP_FLOAT_E_DW = 8;
   localparam int LAMP_FLOAT_F_DW = 7;
   localparam int RES_FIFO_DW     = LAMP_FLOAT_DW + 2;

   typedef struct packed {
      logic overflow;
      logic inexact;
   } lampRndFlags_t;

   typedef struct packed {
      logic [LAMP_FLOAT_E_DW-1:0] exp;
      logic [LAMP_FLOAT_F_DW-1:0] frac;
      lampRndFlags_t              flags;
   } lampRndRes_t;

   // f_res carries the fraction and guard bits only: [9:3]=frac, [2]=G, [1]=R, [0]=S.
   // The hidden bit is implied, so a carry out of the 7-bit fraction bumps the exponent.
   function automatic lampRndRes_t FUNC_rndNearestEven(
      input logic [9:0] f_res,
      input logic [7:0] e_res,
      input logic       is_to_round
   );
      lampRndRes_t r;
      logic        up;
      logic [7:0]  m9;
      r  = '0;
      up = is_to_round & f_res[2] & (f_res[3] | f_res[1] | f_res[0]);
      m9 = {1'b0, f_res[9:3]} + {7'b0, up};
      if (!is_to_round) begin
         // Zero/inf/NaN already encoded by the sqrt unit: pass through untouched.
         r.exp  = e_res;
         r.frac = f_res[9:3];
      end else begin
         r.flags.inexact = |f_res[2:0];
         if (m9[7]) begin
            r.exp  = e_res + 8'd1;
            r.frac = '0;
            // Carry into the all-ones exponent yields infinity (frac already 0).
            r.flags.overflow = (r.exp == 8'hFF);
         end else begin
            r.exp  = e_res;
            r.frac = m9[6:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lamp_fpu_res_fifo.sv
// Synchronous result FIFO with first-word-fall-through head.
//  clk, rst   clock, synchronous active-high reset (empties the FIFO)
//  push/wdata write one entry; ignored (and 'drop' pulses) when full without a pop
//  pop        remove the head; ignored when empty
//  rdata      head entry (valid only while ~empty)
//  full/empty/count occupancy status
//  drop       push attempted while full with no simultaneous pop
module lamp_fpu_res_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 18,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     wdata,
   input  logic             pop,
   output logic [W-1:0]     rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             drop
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count/pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/lamp_fpu_sqrt_round.sv
// Consumer end of the sqrt result interface.
// Rounds the unrounded sqrt result (RNE + carry normalisation), packs a 16-bit
// LAMP float, and buffers it behind a valid/ready output. The sqrt unit cannot
// stall, so the issuer is gated by a credit counter sized to the FIFO.
//  valid_i/s_res_i/e_res_i/f_res_i/isToRound_i  unrounded result from sqrt unit
//  issue_i / can_issue_o                        credit reservation handshake
//  res_o/flags_o/res_valid_o/res_ready_i        buffered output, flags {overflow, inexact}
//  ovf_err_o                                    sticky protocol/overflow error
module lamp_fpu_sqrt_round
   import lamp_fpu_sqrt_round_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic                     s_res_i,
   input  logic [7:0]               e_res_i,
   input  logic [11:0]              f_res_i,
   input  logic                     isToRound_i,
   input  logic                     issue_i,
   output logic                     can_issue_o,
   output logic [LAMP_FLOAT_DW-1:0] res_o,
   output logic [1:0]               flags_o,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic                     ovf_err_o
);

   lampRndRes_t             rnd_res;
   logic                    rnd_valid;
   logic [RES_FIFO_DW-1:0]  rnd_data;
   logic [RES_FIFO_DW-1:0]  head_data;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_drop;
   logic                    pop;
   logic [CNT_W-1:0]        cred;
   logic                    cred_full;
   logic                    unused_ok;

   // Carry bit [11] and hidden bit [10] do not affect rounding; occupancy is
   // tracked by the credit counter instead of the FIFO count.
   assign unused_ok = ^{f_res_i[11:10], fifo_full, fifo_count};

   // ---------------- Stage RND ----------------
   assign rnd_res = FUNC_rndNearestEven(f_res_i[9:0], e_res_i, isToRound_i);

   always_ff @(posedge clk) begin
      if (rst) rnd_valid <= 1'b0;
      else     rnd_valid <= valid_i;
   end

   // Datapath register is qualified by rnd_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (valid_i) rnd_data <= {rnd_res.flags, s_res_i, rnd_res.exp, rnd_res.frac};
   end

   // ---------------- Stage FIFO ----------------
   assign pop = res_valid_o & res_ready_i;

   lamp_fpu_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (RES_FIFO_DW),
      .CNT_W (CNT_W)
   ) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rnd_valid),
      .wdata (rnd_data),
      .pop   (pop),
      .rdata (head_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .drop  (fifo_drop)
   );

   assign res_valid_o = ~fifo_empty;
   // Head is driven from registered storage; forced to zero while empty so
   // the output is clean after reset and between bursts.
   assign res_o   = fifo_empty ? '0 : head_data[LAMP_FLOAT_DW-1:0];
   assign flags_o = fifo_empty ? '0 : head_data[RES_FIFO_DW-1:LAMP_FLOAT_DW];

   // ---------------- Credit counter ----------------
   assign cred_full   = (cred == CNT_W'(FIFO_DEPTH));
   assign can_issue_o = (cred < CNT_W'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         cred <= '0;
      end else if (issue_i && !pop && !cred_full) begin
         cred <= cred + CNT_W'(1);
      end else if (!issue_i && pop) begin
         cred <= cred - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                   ovf_err_o <= 1'b0;
      else if (fifo_drop || (issue_i && cred_full)) ovf_err_o <= 1'b1;
   end

endmodule

// File: tb/tb_lamp_fpu_sqrt_round.sv
module tb_lamp_fpu_sqrt_round;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic        s_res_i = 1'b0;
   logic [7:0]  e_res_i = '0;
   logic [11:0] f_res_i = '0;
   logic        isToRound_i = 1'b0;
   logic        issue_i = 1'b0;
   logic        res_ready_i = 1'b0;
   logic        can_issue_o;
   logic [15:0] res_o;
   logic [1:0]  flags_o;
   logic        res_valid_o;
   logic        ovf_err_o;

   int checks = 0;
   int errors = 0;

   lamp_fpu_sqrt_round #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .s_res_i     (s_res_i),
      .e_res_i     (e_res_i),
      .f_res_i     (f_res_i),
      .isToRound_i (isToRound_i),
      .issue_i     (issue_i),
      .can_issue_o (can_issue_o),
      .res_o       (res_o),
      .flags_o     (flags_o),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .ovf_err_o   (ovf_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rounding from the arithmetic definition: integer mantissa with
   // hidden bit, remainder in eighths, ties go to the even mantissa.
   function automatic logic [17:0] ref_round(input logic s, input logic [7:0] e,
                                             input logic [11:0] f, input logic tr);
      int m, rem, ex;
      logic ovf, inx;
      if (!tr) return {2'b00, s, e, f[9:3]};
      m   = 128 + int'(f[9:3]);
      rem = int'(f[2:0]);
      inx = (rem != 0);
      ovf = 1'b0;
      ex  = int'(e);
      if (rem > 4 || (rem == 4 && (m % 2) == 1)) m = m + 1;
      if (m == 256) begin
         m  = 128;
         ex = (ex + 1) % 256;
         if (ex == 255) ovf = 1'b1;
      end
      return {ovf, inx, s, 8'(ex), 7'(m - 128)};
   endfunction

   // ---------------- Behavioural model + compare ----------------
   // Model state always describes the DUT after the most recent rising edge.
   logic [17:0] mq[$];
   logic        m_pv = 1'b0;
   logic [17:0] m_pd = '0;
   int          mcred = 0;
   logic        movf = 1'b0;
   bit          chk_en = 1'b0;
   bit          m_pop;
   logic [17:0] m_head;

   always @(negedge clk) begin
      if (chk_en) begin
         check("res_valid", res_valid_o, mq.size() > 0);
         if (mq.size() > 0) begin
            m_head = mq[0];
            check("res_o", res_o, m_head[15:0]);
            check("flags_o", flags_o, m_head[17:16]);
         end
         check("can_issue", can_issue_o, mcred < DEPTH);
         check("ovf_err", ovf_err_o, movf);
      end
      // Advance model with the inputs the next rising edge will sample.
      if (rst) begin
         mq.delete();
         m_pv  = 1'b0;
         mcred = 0;
         movf  = 1'b0;
      end else begin
         m_pop = (mq.size() > 0) && res_ready_i;
         if (issue_i && mcred == DEPTH) movf = 1'b1;
         if (issue_i && !m_pop && mcred < DEPTH) mcred = mcred + 1;
         else if (!issue_i && m_pop)              mcred = mcred - 1;
         if (m_pop) void'(mq.pop_front());
         if (m_pv) begin
            if (mq.size() < DEPTH) mq.push_back(m_pd);
            else                   movf = 1'b1;
         end
         m_pv = valid_i;
         m_pd = ref_round(s_res_i, e_res_i, f_res_i, isToRound_i);
      end
   end

   // ---------------- Stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_res(input logic v, input logic iss, input logic s, input logic [7:0] e,
                          input logic [11:0] f, input logic tr);
      valid_i     = v;
      issue_i     = iss;
      s_res_i     = s;
      e_res_i     = e;
      f_res_i     = f;
      isToRound_i = tr;
   endtask

   typedef struct {
      logic        s;
      logic [7:0]  e;
      logic [11:0] f;
      logic        tr;
      logic [15:0] res;
      logic [1:0]  flg;
   } vec_t;

   vec_t vecs[7];
   int   pending;

   initial begin
      vecs[0] = '{1'b0, 8'h7F, 12'h404, 1'b1, 16'h3F80, 2'b01}; // tie, L=0: stays
      vecs[1] = '{1'b0, 8'h7F, 12'h40C, 1'b1, 16'h3F82, 2'b01}; // tie, L=1: rounds up
      vecs[2] = '{1'b0, 8'h7F, 12'h7FE, 1'b1, 16'h4000, 2'b01}; // carry to exp+1
      vecs[3] = '{1'b0, 8'hFE, 12'h7FE, 1'b1, 16'h7F80, 2'b11}; // carry to inf
      vecs[4] = '{1'b0, 8'hFF, 12'h600, 1'b0, 16'h7FC0, 2'b00}; // special pass-through
      vecs[5] = '{1'b0, 8'h7F, 12'h400, 1'b1, 16'h3F80, 2'b00}; // exact
      vecs[6] = '{1'b1, 8'h80, 12'h4FF, 1'b1, 16'hC020, 2'b01}; // above half, negative

      repeat (3) cyc();
      chk_en = 1'b1;
      check("rst_res_valid", res_valid_o, 1'b0);
      check("rst_res_o", res_o, 16'h0);
      check("rst_flags", flags_o, 2'b00);
      check("rst_ovf", ovf_err_o, 1'b0);
      check("rst_can_issue", can_issue_o, 1'b1);
      rst = 1'b0;
      res_ready_i = 1'b1;
      cyc();

      // Directed rounding vectors, one at a time through an empty FIFO.
      foreach (vecs[i]) begin
         set_res(1'b1, 1'b1, vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].tr);
         check("model_pin_res", ref_round(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].tr),
               {vecs[i].flg, vecs[i].res});
         cyc();
         set_res(1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b0);
         cyc();
         check("lat2_valid", res_valid_o, 1'b1);
         check("vec_res", res_o, vecs[i].res);
         check("vec_flags", flags_o, vecs[i].flg);
         cyc();
      end
      repeat (2) cyc();

      // Backpressure: fill the FIFO, check head stability and overflow.
      res_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_res(1'b1, 1'b1, 1'b0, 8'(8'h10 + i), 12'h400, 1'b1);
         cyc();
      end
      set_res(1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b0);
      repeat (3) cyc();
      check("bp_can_issue", can_issue_o, 1'b0);
      check("bp_valid", res_valid_o, 1'b1);
      check("bp_head", res_o, 16'h0800);
      check("bp_ovf_before", ovf_err_o, 1'b0);
      set_res(1'b1, 1'b0, 1'b0, 8'h20, 12'h400, 1'b1);
      cyc();
      set_res(1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b0);
      repeat (2) cyc();
      check("bp_ovf_after", ovf_err_o, 1'b1);
      check("bp_head_stable", res_o, 16'h0800);
      res_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("bp_drain", res_o, 16'(16'h0800 + 16'h0080 * i));
         cyc();
      end
      check("bp_empty", res_valid_o, 1'b0);
      check("bp_cred_back", can_issue_o, 1'b1);

      // Reset with entries queued; a valid_i during the reset cycle is ignored.
      res_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_res(1'b1, 1'b1, 1'b0, 8'h40, 12'h4A5, 1'b1);
         cyc();
      end
      set_res(1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b0);
      repeat (3) cyc();
      check("rq_valid", res_valid_o, 1'b1);
      rst = 1'b1;
      set_res(1'b1, 1'b0, 1'b0, 8'h55, 12'h555, 1'b1);
      cyc();
      rst = 1'b0;
      set_res(1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b0);
      check("rq_valid_cleared", res_valid_o, 1'b0);
      check("rq_can_issue", can_issue_o, 1'b1);
      check("rq_ovf_cleared", ovf_err_o, 1'b0);
      repeat (3) cyc();
      check("rq_ignored_valid", res_valid_o, 1'b0);

      // Randomised traffic obeying the credit protocol.
      pending = 0;
      for (int n = 0; n < 3000; n++) begin
         logic iss, v, tr;
         logic [11:0] f;
         iss = (mcred < DEPTH) && ($urandom_range(0, 99) < 60);
         v   = ((pending > 0) || iss) && ($urandom_range(0, 99) < 55);
         tr  = ($urandom_range(0, 9) != 0);
         f   = tr ? {2'b01, 10'($urandom)} : {1'b0, 11'($urandom)};
         set_res(v, iss, 1'($urandom), tr ? 8'($urandom_range(0, 254)) : 8'($urandom),
                 f, tr);
         res_ready_i = ($urandom_range(0, 99) < 65);
         pending = pending + int'(iss) - int'(v);
         cyc();
      end
      set_res(1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b0);
      res_ready_i = 1'b1;
      repeat (10) cyc();
      check("final_empty", res_valid_o, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
